ram_banked_ctrl: RTL and testbench

Parametrised, multi-bank, byte-writable single-port SRAM controller; successor to the fixed 128-word macro wrapper. It adds a valid/ready request port, a registered read-response channel, per-bank chip-enable gating and a post-reset zero-fill engine. It sits between the user-project bus adapters (e.g. AXI-Lite/Wishbone slave datapaths) and the technology SRAM macros. It presents one flat word-addressed memory of `NBANK << BAW` words.

---
 rtl/ram_banked_pkg.sv | 13 +
 rtl/ram_banked_ctrl_bank.sv | 46 ++++
 rtl/ram_banked_ctrl.sv | 102 ++++++++++
 tb/tb_ram_banked_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ram_banked_pkg.sv
// Shared types and defaults for the banked SRAM controller.
// bank_of() maps a flat word address to its bank index.
package ram_banked_pkg;
  typedef enum logic {INIT, IDLE} state_e;

  localparam int DEF_WSIZE = 4;
  localparam int DEF_BAW   = 7;
  localparam int DEF_NBANK = 2;

  function automatic logic [31:0] bank_of(input logic [31:0] addr, input int baw);
    return addr >> baw;
  endfunction
endpackage

// File: rtl/ram_banked_ctrl_bank.sv
// One 2**BAW x WSIZE*8 bank built from byte-wide macros, with a
// behavioural fallback when no SRAM macro library is selected.
module ram_bank #(
  parameter int WSIZE = 4,
  parameter int BAW   = 7
) (
`ifdef USE_POWER_PINS
  inout  wire                  vccd1,
  inout  wire                  vssd1,
`endif
  input  logic                 clk,
  input  logic                 en,
  input  logic [WSIZE-1:0]     we,
  input  logic [BAW-1:0]       addr,
  input  logic [WSIZE*8-1:0]   wdata,
  output logic [WSIZE*8-1:0]   rdata
);
  for (genvar b = 0; b < WSIZE; b++) begin : g_byte
`ifdef USE_EDK_SRAM
    sram_edk_8b u_mac (
`ifdef USE_POWER_PINS
      .vccd1(vccd1), .vssd1(vssd1),
`endif
      .CLK(clk), .EN(en), .WE(we[b]), .A(addr),
      .Di(wdata[b*8 +: 8]), .Do(rdata[b*8 +: 8]));
`elsif USE_PDK_SRAM
    sram_pdk_8b u_mac (
`ifdef USE_POWER_PINS
      .vccd1(vccd1), .vssd1(vssd1),
`endif
      .CLK(clk), .EN(en), .WE(we[b]), .A(addr),
      .Di(wdata[b*8 +: 8]), .Do(rdata[b*8 +: 8]));
`else
    logic [7:0] mem [2**BAW];
    logic [7:0] rdata_q;
    // Data out only moves on reads, like the macros' registered output.
    always_ff @(posedge clk) begin
      if (en) begin
        if (we[b]) mem[addr] <= wdata[b*8 +: 8];
        else if (we == '0) rdata_q <= mem[addr];
      end
    end
    assign rdata[b*8 +: 8] = rdata_q;
`endif
  end
endmodule

// File: rtl/ram_banked_ctrl.sv
// Banked byte-writable SRAM controller: valid/ready request port,
// 1-cycle registered read response, per-bank enables, post-reset zero fill.
module ram_banked_ctrl
  import ram_banked_pkg::*;
#(
  parameter int WSIZE = DEF_WSIZE,
  parameter int BAW   = DEF_BAW,
  parameter int NBANK = DEF_NBANK,
  parameter int AW    = BAW + $clog2(NBANK)
) (
`ifdef USE_POWER_PINS
  inout  wire                 vccd1,
  inout  wire                 vssd1,
`endif
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [WSIZE-1:0]    req_we,
  input  logic [AW-1:0]       req_addr,
  input  logic [WSIZE*8-1:0]  req_wdata,
  output logic                rsp_valid,
  output logic [WSIZE*8-1:0]  rsp_rdata,
  output logic                init_done
);
  localparam int DW = WSIZE * 8;
  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

  state_e               state_q, state_d;
  logic [BAW-1:0]       init_ptr_q, init_ptr_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [BW-1:0]        rd_bank_q, rd_bank_d;
  logic [DW-1:0]        hold_q, hold_d;

  logic                 accept, is_rd;
  logic [BW-1:0]        sel_bank;
  logic [NBANK-1:0]     bank_en;
  logic [WSIZE-1:0]     mem_we;
  logic [BAW-1:0]       mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic [NBANK-1:0][DW-1:0] bank_rdata;
  logic [DW-1:0]        rd_mux;

  assign sel_bank = BW'(bank_of(32'(req_addr), BAW));
  assign rd_mux   = bank_rdata[rd_bank_q];

  always_comb begin
    state_d     = state_q;
    init_ptr_d  = init_ptr_q;
    accept      = (state_q == IDLE) && req_valid;
    is_rd       = accept && (req_we == '0);
    bank_en     = '0;
    mem_we      = req_we;
    mem_addr    = req_addr[BAW-1:0];
    mem_wdata   = req_wdata;
    if (state_q == INIT) begin
      // Zero-fill the same local address in every bank at once.
      bank_en    = '1;
      mem_we     = '1;
      mem_addr   = init_ptr_q;
      mem_wdata  = '0;
      init_ptr_d = init_ptr_q + 1'b1;
      if (&init_ptr_q) state_d = IDLE;
    end else if (accept) begin
      bank_en[sel_bank] = 1'b1;
    end
    rsp_valid_d = is_rd;
    rd_bank_d   = is_rd ? sel_bank : rd_bank_q;
    // Bank outputs may move later; keep the last response stable here.
    hold_d      = rsp_valid_q ? rd_mux : hold_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= INIT;
      init_ptr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rd_bank_q   <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rd_bank_q   <= rd_bank_d;
      hold_q      <= hold_d;
    end
  end

  for (genvar k = 0; k < NBANK; k++) begin : g_bank
    ram_bank #(.WSIZE(WSIZE), .BAW(BAW)) u_bank (
`ifdef USE_POWER_PINS
      .vccd1(vccd1), .vssd1(vssd1),
`endif
      .clk(CLK), .en(bank_en[k]), .we(mem_we), .addr(mem_addr),
      .wdata(mem_wdata), .rdata(bank_rdata[k]));
  end

  assign req_ready = (state_q == IDLE);
  assign init_done = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_valid_q ? rd_mux : hold_q;
endmodule

// File: tb/tb_ram_banked_ctrl.sv
// Directed bench for ram_banked_ctrl: vector table on the default build,
// hand sequences for reset corners, and a random scoreboard on a small build.
module tb_ram_banked_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic [3:0]  req_we = '0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, init_done;
  logic [31:0] rsp_rdata;

  logic        rst2 = 1'b1;
  logic        v2 = 1'b0;
  logic [1:0]  we2 = '0;
  logic [6:0]  a2 = '0;
  logic [15:0] wd2 = '0;
  logic        rdy2, rv2, done2;
  logic [15:0] rd2;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  ram_banked_ctrl dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done));

  ram_banked_ctrl #(.WSIZE(2), .BAW(5), .NBANK(4)) dut2 (
    .CLK(CLK), .RST(rst2), .req_valid(v2), .req_ready(rdy2),
    .req_we(we2), .req_addr(a2), .req_wdata(wd2),
    .rsp_valid(rv2), .rsp_rdata(rd2), .init_done(done2));

  typedef struct {
    logic [3:0]  we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        exp_vld;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Counts edges until req_ready rises, bounded.
  task automatic count_fill(output int n);
    n = 0;
    while (!req_ready && n < 400) begin
      tick();
      n++;
    end
  endtask

  vec_t vecs[17];
  logic [15:0] model [128];

  initial begin
    int n;
    vecs[0]  = '{4'h0, 8'h00, 32'h0,        1'b1, 32'h00000000};
    vecs[1]  = '{4'h0, 8'h7F, 32'h0,        1'b1, 32'h00000000};
    vecs[2]  = '{4'h0, 8'h80, 32'h0,        1'b1, 32'h00000000};
    vecs[3]  = '{4'h0, 8'hFF, 32'h0,        1'b1, 32'h00000000};
    vecs[4]  = '{4'hF, 8'h05, 32'hDEADBEEF, 1'b0, 32'h00000000};
    vecs[5]  = '{4'h5, 8'h05, 32'h11223344, 1'b0, 32'h00000000};
    vecs[6]  = '{4'h0, 8'h05, 32'h0,        1'b1, 32'hDE22BE44};
    vecs[7]  = '{4'hF, 8'h10, 32'hAAAA0001, 1'b0, 32'hDE22BE44};
    vecs[8]  = '{4'hF, 8'h90, 32'h55550002, 1'b0, 32'hDE22BE44};
    vecs[9]  = '{4'h0, 8'h10, 32'h0,        1'b1, 32'hAAAA0001};
    vecs[10] = '{4'h0, 8'h90, 32'h0,        1'b1, 32'h55550002};
    vecs[11] = '{4'hF, 8'h7F, 32'h12345678, 1'b0, 32'h55550002};
    vecs[12] = '{4'h0, 8'h7F, 32'h0,        1'b1, 32'h12345678};
    vecs[13] = '{4'h3, 8'h90, 32'h0000FFFF, 1'b0, 32'h12345678};
    vecs[14] = '{4'h0, 8'h90, 32'h0,        1'b1, 32'h5555FFFF};
    vecs[15] = '{4'h0, 8'h10, 32'h0,        1'b1, 32'hAAAA0001};
    vecs[16] = '{4'h0, 8'h05, 32'h0,        1'b1, 32'hDE22BE44};

    // Reset state and fill length
    repeat (3) tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    RST = 1'b0;
    count_fill(n);
    chk("fill_cycles", n, 128);
    chk("fill_done", 32'(init_done), 32'd1);

    // Vector table, one request per cycle
    for (int i = 0; i < 17; i++) begin
      req_valid = 1'b1;
      req_we    = vecs[i].we;
      req_addr  = vecs[i].addr;
      req_wdata = vecs[i].wdata;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_vld));
      chk($sformatf("vec%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
    end
    req_valid = 1'b0;
    req_we    = '0;
    #1;
    chk("idle_bank_en", 32'(dut.bank_en), 32'b00);
    tick();
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_rdata_hold", rsp_rdata, 32'hDE22BE44);

    // Bank enable gating
    req_valid = 1'b1; req_we = 4'hF; req_addr = 8'h90; req_wdata = 32'h55550002;
    #1;
    chk("en_wr_0x90", 32'(dut.bank_en), 32'b10);
    tick();
    req_we = 4'h0;
    #1;
    chk("en_rd_0x90", 32'(dut.bank_en), 32'b10);
    tick();
    chk("rd_0x90", rsp_rdata, 32'h55550002);
    req_addr = 8'h10;
    #1;
    chk("en_rd_0x10", 32'(dut.bank_en), 32'b01);
    tick();
    chk("rd_0x10", rsp_rdata, 32'hAAAA0001);

    // Reset arriving with a read: no response, then mid-fill restart
    req_addr = 8'h05;
    RST = 1'b1;
    tick();
    req_valid = 1'b0;
    RST = 1'b0;
    chk("rst_rd_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rd_rdata", rsp_rdata, 32'h0);
    repeat (60) tick();
    chk("midfill_ready", 32'(req_ready), 32'd0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    count_fill(n);
    chk("refill_cycles", n, 128);
    req_valid = 1'b1; req_we = 4'h0; req_addr = 8'h05;
    tick();
    req_valid = 1'b0;
    chk("refill_rd_05", rsp_rdata, 32'h0);
    chk("refill_rd_valid", 32'(rsp_valid), 32'd1);

    // Small build: fill length and random scoreboard
    repeat (2) tick();
    rst2 = 1'b0;
    n = 0;
    while (!rdy2 && n < 400) begin
      tick();
      n++;
    end
    chk("p_fill_cycles", n, 32);
    for (int i = 0; i < 128; i++) model[i] = 16'h0;
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  w;
      logic [6:0]  a;
      logic [15:0] d;
      w = 2'($urandom_range(0, 3));
      a = 7'($urandom_range(0, 127));
      d = 16'($urandom);
      v2 = 1'b1; we2 = w; a2 = a; wd2 = d;
      tick();
      if (w == 2'b00) begin
        chk($sformatf("p_rd_%02h", a), {15'h0, rv2, rd2}, {15'h0, 1'b1, model[a]});
      end else begin
        if (w[0]) model[a][7:0]  = d[7:0];
        if (w[1]) model[a][15:8] = d[15:8];
      end
    end
    v2 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
